serial_pattern_detector: RTL and testbench
==========================================

Name: serial_pattern_detector

Overview:
- Parametrised serial bit-stream monitor, next generation of the team's 2-bit XNOR transition detector.
- Samples a 1-bit serial input into a WIDTH-bit window and compares the window against a loadable pattern with a per-bit don't-care mask.
- Outputs a registered match pulse, a saturating match counter, and a registered "same as previous bit" flag, which is the legacy transition-detector function.
- Sits between a serial receive front end and the control logic that consumes frame/sync events.

Parameters:
- WIDTH, 4, pattern/window length in bits; legal 2..16.
- CNT_W, 8, match counter width in bits; legal 2..16.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- en  input  1  sample enable; din is consumed only on edges where en=1
- din  input  1  serial data bit
- load  input  1  latch pattern/mask and restart detection
- pattern  input  WIDTH  target sequence; bit WIDTH-1 is the oldest bit, bit 0 is the newest
- mask  input  WIDTH  1 = compare this bit, 0 = don't care
- overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping; sampled live every cycle
- clr_cnt  input  1  synchronous clear of count
- match  output  1  one-cycle pulse on detection
- same  output  1  registered XNOR of current sampled bit and previous sampled bit
- count  output  CNT_W  saturating number of matches
- armed  output  1  window holds WIDTH valid bits

Behaviour:
- Reset (async, rst=1):
  - window sr=0, fill=0, prev=0, pat_r=0, mask_r=all ones.
  - Outputs: match=0, same=0, count=0, armed=0.
- Sample edge (en=1, load=0):
  - sr <= {sr[WIDTH-2:0], din}.
  - prev <= din.
  - same <= ~(prev ^ din).
  - fill increments, saturating at WIDTH.
- en=0 edge:
  - sr, fill, prev and same hold.
  - match <= 0.
- Candidate window: cand = {sr[WIDTH-2:0], din}.
- hit = en & ~load & (fill >= WIDTH-1) & (((cand ^ pat_r) & mask_r) == 0).
- Latency: match <= hit. The pulse is high for exactly the clock cycle following the edge that sampled the completing bit (1-cycle latency, same as the legacy block).
- On hit with overlap=1:
  - Window continues shifting.
  - A new match is possible on the very next sample if the pattern self-overlaps.
- On hit with overlap=0:
  - fill <= 0, so the next match requires WIDTH fresh samples.
  - sr still shifts.
- armed = (fill == WIDTH), registered.
- count:
  - On hit, count <= count+1, saturating at 2^CNT_W-1 (no wrap).
  - clr_cnt=1 forces count <= 0 and takes priority over a same-cycle hit.
- load=1 edge (priority over en):
  - pat_r <= pattern, mask_r <= mask.
  - sr <= 0, fill <= 0, match <= 0, armed <= 0.
  - din on that edge is discarded; prev and same hold.
  - count is NOT affected.
- mask all zeros: every sample matches once fill >= WIDTH-1. This is legal and defined, not an error.
- Reset asserted mid-stream: all state clears immediately. The first match after release requires WIDTH samples.
- Internal state: fill counter only (no explicit FSM states beyond fill < WIDTH-1 → "filling", fill ≥ WIDTH-1 → "armed/compare").

Test Plan:
- WIDTH=4, load pattern=1011, mask=1111, overlap=1, en=1, din stream 1,0,1,1,0,1,1 -> match pulses one cycle after samples 4 and 7; count=2; armed rises after sample 4.
- Same setup with overlap=0, stream 1,0,1,1,0,1,1,0,1,1 -> match after samples 4 and 10 only; count=2.
- pattern=1001, mask=1001, stream 1,1,0,1 and 1,0,1,1 -> match after each 4th sample; stream 0,1,1,1 -> no match.
- After reset, en=1, din 0,0,1,1,0 -> same = 1,1,0,1,0 on successive cycles; en=0 for 2 cycles holds same=0 and match=0.
- CNT_W=2, mask=0000, 8 samples -> count saturates at 3; clr_cnt asserted with a hit -> count=0.
- Assert rst for 1 cycle after 3 of 4 pattern bits, then send the final bit -> no match; full pattern afterwards -> match; a load on the completing edge -> no match and din discarded.

Source files
------------

// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: shifts a serial bit stream into a window and flags masked pattern matches,
// with a saturating match counter and a registered same-as-previous-bit flag.
module serial_pattern_detector #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] mask,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             match,
    output logic             same,
    output logic [CNT_W-1:0] count,
    output logic             armed
);
    localparam int FW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] sr, pat_r, mask_r, cand;
    logic [FW-1:0] fill, fill_nx;
    logic prev, hit;
    assign cand = {sr[WIDTH-2:0], din};
    assign hit = en & ~load & (fill >= FW'(WIDTH - 1)) & (((cand ^ pat_r) & mask_r) == '0);
    // A non-overlapping hit restarts the fill so the next match needs WIDTH fresh samples.
    always_comb fill_nx = (hit & ~overlap) ? '0 : (fill == FW'(WIDTH)) ? fill : fill + 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr     <= '0;
            fill   <= '0;
            prev   <= 1'b0;
            pat_r  <= '0;
            mask_r <= '1;
            match  <= 1'b0;
            same   <= 1'b0;
            count  <= '0;
            armed  <= 1'b0;
        end else begin
            count <= clr_cnt ? '0 : (hit && count != '1) ? count + 1'b1 : count;
            if (load) begin
                pat_r  <= pattern;
                mask_r <= mask;
                sr     <= '0;
                fill   <= '0;
                match  <= 1'b0;
                armed  <= 1'b0;
            end else if (en) begin
                sr    <= cand;
                prev  <= din;
                same  <= ~(prev ^ din);
                fill  <= fill_nx;
                match <= hit;
                armed <= (fill_nx == FW'(WIDTH));
            end else begin
                match <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_pattern_detector.sv
// tb_serial_pattern_detector: vector table, hand-written corner sequences and random stimulus
// checked against a queue-based reference model.
module tb_serial_pattern_detector;
    localparam int W = 4;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, din = 1'b0, load = 1'b0, overlap = 1'b1, clr_cnt = 1'b0;
    logic [W-1:0] pattern = '0, mask = '1;
    logic match, same, armed, match2, same2, armed2;
    logic [7:0] count;
    logic [1:0] count2;
    int tests = 0, fails = 0, pulses = 0;

    always #5 clk = ~clk;

    serial_pattern_detector #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .load(load), .pattern(pattern), .mask(mask),
        .overlap(overlap), .clr_cnt(clr_cnt), .match(match), .same(same), .count(count), .armed(armed)
    );
    serial_pattern_detector #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .din(din), .load(load), .pattern(pattern), .mask(mask),
        .overlap(overlap), .clr_cnt(clr_cnt), .match(match2), .same(same2), .count(count2), .armed(armed2)
    );

    // reference model: bits since last load/reset, fresh-sample count, output values
    bit q[$];
    int fresh, m_cnt, m_cnt2;
    bit m_prev, m_same, m_match, m_armed;
    bit [W-1:0] m_pat, m_msk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("match", match, m_match);
        check("same", same, m_same);
        check("count", count, m_cnt);
        check("armed", armed, m_armed);
        check("count2", count2, m_cnt2);
        check("match2", match2, m_match);
    endtask

    task automatic model_reset();
        q.delete();
        fresh = 0; m_cnt = 0; m_cnt2 = 0;
        m_prev = 0; m_same = 0; m_match = 0; m_armed = 0;
        m_pat = '0; m_msk = '1;
    endtask

    task automatic model_step();
        bit hit, ok, b;
        ok = 1;
        if (fresh >= W - 1)
            for (int i = 0; i < W; i++) begin
                b = (i == 0) ? din : q[q.size() - i];
                if (m_msk[i] && b != m_pat[i]) ok = 0;
            end
        hit = en && !load && fresh >= W - 1 && ok;
        if (clr_cnt) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (load) begin
            m_pat = pattern; m_msk = mask;
            q.delete(); fresh = 0; m_match = 0; m_armed = 0;
        end else if (en) begin
            m_same = (m_prev == din);
            m_prev = din;
            q.push_back(din);
            if (q.size() > W) void'(q.pop_front());
            fresh = (hit && !overlap) ? 0 : (fresh < W ? fresh + 1 : W);
            m_match = hit;
            m_armed = (fresh == W);
        end else begin
            m_match = 0;
        end
    endtask

    task automatic step(input logic e, input logic d, input logic l, input logic o, input logic c);
        en = e; din = d; load = l; overlap = o; clr_cnt = c;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        if (match) pulses++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    task automatic send(input logic [15:0] bits, input int n, input logic o);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, o, 1'b0);
    endtask

    task automatic do_load(input logic [W-1:0] p, input logic [W-1:0] m);
        pattern = p; mask = m;
        step(1'b1, 1'b0, 1'b1, overlap, 1'b0);
    endtask

    typedef struct {
        logic e, d, l;
        logic [W-1:0] p, m;
        logic em, es;
        int ec;
        logic ea;
    } vec_t;
    vec_t tv[15];

    initial begin
        tv[0]  = '{1, 0, 0, 4'h0, 4'hf, 0, 1, 0, 0};
        tv[1]  = '{1, 0, 0, 4'h0, 4'hf, 0, 1, 0, 0};
        tv[2]  = '{1, 1, 0, 4'h0, 4'hf, 0, 0, 0, 0};
        tv[3]  = '{1, 1, 0, 4'h0, 4'hf, 0, 1, 0, 1};
        tv[4]  = '{1, 0, 0, 4'h0, 4'hf, 0, 0, 0, 1};
        tv[5]  = '{0, 1, 0, 4'h0, 4'hf, 0, 0, 0, 1};
        tv[6]  = '{0, 0, 0, 4'h0, 4'hf, 0, 0, 0, 1};
        tv[7]  = '{1, 1, 1, 4'hb, 4'hf, 0, 0, 0, 0};
        tv[8]  = '{1, 1, 0, 4'hb, 4'hf, 0, 0, 0, 0};
        tv[9]  = '{1, 0, 0, 4'hb, 4'hf, 0, 0, 0, 0};
        tv[10] = '{1, 1, 0, 4'hb, 4'hf, 0, 0, 0, 0};
        tv[11] = '{1, 1, 0, 4'hb, 4'hf, 1, 1, 1, 1};
        tv[12] = '{1, 0, 0, 4'hb, 4'hf, 0, 0, 1, 1};
        tv[13] = '{1, 1, 0, 4'hb, 4'hf, 0, 0, 1, 1};
        tv[14] = '{1, 1, 0, 4'hb, 4'hf, 1, 1, 2, 1};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            pattern = tv[i].p; mask = tv[i].m;
            step(tv[i].e, tv[i].d, tv[i].l, 1'b1, 1'b0);
            check($sformatf("tv%0d.match", i), match, tv[i].em);
            check($sformatf("tv%0d.same", i), same, tv[i].es);
            check($sformatf("tv%0d.count", i), count, tv[i].ec);
            check($sformatf("tv%0d.armed", i), armed, tv[i].ea);
        end

        // non-overlapping: hits after samples 4 and 10 only
        overlap = 1'b0;
        do_load(4'b1011, 4'b1111);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pulses = 0;
        send(16'b1011011011, 10, 1'b0);
        check("novl.count", count, 2);
        check("novl.pulses", pulses, 2);
        check("novl.last", match, 1);

        // partial mask 1001
        overlap = 1'b1;
        pulses = 0;
        do_load(4'b1001, 4'b1001);
        send(16'b1101, 4, 1'b1);
        check("mask.1101", match, 1);
        do_load(4'b1001, 4'b1001);
        send(16'b1011, 4, 1'b1);
        check("mask.1011", match, 1);
        do_load(4'b1001, 4'b1001);
        send(16'b0111, 4, 1'b1);
        check("mask.0111", match, 0);
        check("mask.pulses", pulses, 2);

        // all-zero mask saturates the 2-bit counter; clear wins over a hit
        do_load(4'b0000, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(16'hA5, 8, 1'b1);
        check("sat.count2", count2, 3);
        check("sat.count", count, 5);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("clr.count", count, 0);
        check("clr.count2", count2, 0);
        check("clr.match", match, 1);

        // reset mid-pattern, then load on the completing edge
        do_load(4'b1011, 4'b1111);
        send(16'b101, 3, 1'b1);
        do_reset();
        send(16'b1, 1, 1'b1);
        check("rst.nomatch", match, 0);
        do_load(4'b1011, 4'b1111);
        send(16'b1011, 4, 1'b1);
        check("rst.rematch", match, 1);
        send(16'b101, 3, 1'b1);
        pulses = 0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("ldc.match", match, 0);
        check("ldc.armed", armed, 0);
        send(16'b011, 3, 1'b1);
        check("ldc.pulses", pulses, 0);

        // randomized run against the reference model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(149) == 0) do_reset();
            else begin
                pattern = W'($urandom);
                mask = ($urandom_range(7) == 0) ? '0 : W'($urandom);
                step(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom_range(49) == 0),
                     1'($urandom), 1'($urandom_range(39) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
